fir_filter_mc: RTL

//  Parametrised multi-channel FIR filter. Generalises the fixed 5-tap 1-2-4-2-1 low-pass
//  to TAPS programmable signed coefficients, CHANNELS time-multiplexed streams, one

---
 rtl/fir_filter_mc.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fir_filter_mc.sv
// ============================================================================
// fir_filter_mc : multi-channel FIR, one sequential MAC, round/shift/saturate
// Rev 1.0
// ============================================================================
`default_nettype none

module fir_filter_mc #(
    parameter int DATA_W   = 32,
    parameter int COEF_W   = 16,
    parameter int TAPS     = 5,
    parameter int CHANNELS = 2,
    parameter int SHIFT    = 0,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int TA_W    = $clog2(TAPS),
    localparam int ACC_W   = DATA_W + COEF_W + TA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_W-1:0]          in_chan,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_chan,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_sat,
    input  logic                     coef_we,
    input  logic [TA_W-1:0]          coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     coef_commit,
    output logic                     coef_pending
);

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

    localparam logic signed [ACC_W:0] RND  = ((ACC_W+1)'(1) << SHIFT) >> 1;
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t                     state, state_nxt;
    logic signed [DATA_W-1:0]   line     [CHANNELS][TAPS];
    logic signed [COEF_W-1:0]   c_shadow [TAPS];
    logic signed [COEF_W-1:0]   c_active [TAPS];
    logic signed [ACC_W-1:0]    acc;
    logic [TA_W-1:0]            k;
    logic [CH_W-1:0]            chan;
    logic                       flush_pend;

    logic                       flush_req, accept, do_flush, commit_req, do_copy, last;
    logic signed [ACC_W-1:0]    prod, sum;
    logic signed [ACC_W:0]      rnd, res;
    logic                       sat_hi, sat_lo;

    assign flush_req  = flush | flush_pend;
    assign in_ready   = (state == IDLE) && !flush_req;
    assign out_valid  = (state == OUT);
    // Out-of-range channels complete the handshake but are dropped.
    assign accept     = in_valid && in_ready && (int'(in_chan) < CHANNELS);
    assign do_flush   = (state == IDLE) && flush_req;
    assign commit_req = coef_pending | coef_commit;
    assign do_copy    = (state == IDLE) && commit_req && !accept;
    assign last       = (k == TA_W'(TAPS-1));

    assign prod   = ACC_W'(c_active[k]) * ACC_W'(line[chan][k]);
    assign sum    = acc + prod;
    assign rnd    = $signed((ACC_W+1)'(sum)) + RND;
    assign res    = rnd >>> SHIFT;
    assign sat_hi = res > MAXV;
    assign sat_lo = res < MINV;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = MAC;
            MAC:     if (last)      state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            acc          <= '0;
            k            <= '0;
            chan         <= '0;
            flush_pend   <= 1'b0;
            coef_pending <= 1'b0;
            out_chan     <= '0;
            out_data     <= '0;
            out_sat      <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                c_shadow[i] <= (i == TAPS/2) ? (COEF_W'(1) << SHIFT) : '0;
                c_active[i] <= (i == TAPS/2) ? (COEF_W'(1) << SHIFT) : '0;
            end
            for (int c = 0; c < CHANNELS; c++)
                for (int i = 0; i < TAPS; i++)
                    line[c][i] <= '0;
        end else begin
            state        <= state_nxt;
            flush_pend   <= flush_req && (state != IDLE);
            coef_pending <= commit_req && !do_copy;

            if (coef_we && (int'(coef_addr) < TAPS))
                c_shadow[coef_addr] <= coef_data;
            // A write landing in the copy cycle is forwarded into the active bank.
            if (do_copy)
                for (int i = 0; i < TAPS; i++)
                    c_active[i] <= (coef_we && int'(coef_addr) == i) ? coef_data : c_shadow[i];

            if (do_flush) begin
                for (int c = 0; c < CHANNELS; c++)
                    for (int i = 0; i < TAPS; i++)
                        line[c][i] <= '0;
            end else if (accept) begin
                line[in_chan][0] <= in_data;
                for (int i = 1; i < TAPS; i++)
                    line[in_chan][i] <= line[in_chan][i-1];
            end

            if (accept) begin
                chan <= in_chan;
                acc  <= '0;
                k    <= '0;
            end else if (state == MAC) begin
                acc <= sum;
                k   <= k + TA_W'(1);
                if (last) begin
                    out_chan <= chan;
                    out_sat  <= sat_hi | sat_lo;
                    out_data <= sat_hi ? MAXV[DATA_W-1:0] :
                                sat_lo ? MINV[DATA_W-1:0] : res[DATA_W-1:0];
                end
            end
        end
    end

endmodule

`default_nettype wire
